// File: rtl/pipe_pkg.sv
// Shared pipeline types and widths for the 5-stage MIPS datapath.
// The control bundle and its bubble value are reused by every
// inter-stage register that carries EX/MEM/WB control.
package pipe_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int ALUOP_W = 4;

  typedef struct packed {
    logic               regWrite;
    logic               memRead;
    logic               memWrite;
    logic               memToReg;
    logic               aluSrc;
    logic [ALUOP_W-1:0] aluOp;
  } ctrl_t;

  // A bubble must not write the register file or memory; all-zero does that.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: the instruction in EX is a load whose
// destination (never r0) is a source of the instruction sitting in ID.
// Purely combinational.
module load_use_detect #(
  parameter int REG_W = pipe_pkg::REG_W
) (
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             hz
);

  // r0 is hardwired to zero, so a load targeting it creates no dependence.
  always_comb begin
    hz = ex_mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation.
// Priority each edge: rst > ext_hold (freeze) > flush > hazard bubble > load.
// Optional macro STALL_COUNT_EN adds free-running stall/flush event counters
// (stall_cycles, flush_cycles); without it those ports do not exist.
import pipe_pkg::*;

module id_ex_stage #(
  parameter int DATA_W  = pipe_pkg::DATA_W,
  parameter int REG_W   = pipe_pkg::REG_W,
  parameter int ALUOP_W = pipe_pkg::ALUOP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ext_hold,
  input  logic               flush,
  input  logic [REG_W-1:0]   IF_ID_rs,
  input  logic [REG_W-1:0]   IF_ID_rt,
  input  logic [REG_W-1:0]   IF_ID_rd,
  input  logic               id_regWrite,
  input  logic               id_memRead,
  input  logic               id_memWrite,
  input  logic               id_memToReg,
  input  logic               id_aluSrc,
  input  logic               id_regDst,
  input  logic [ALUOP_W-1:0] id_aluOp,
  input  logic [DATA_W-1:0]  id_rsData,
  input  logic [DATA_W-1:0]  id_rtData,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [DATA_W-1:0]  id_pc4,
  output logic [REG_W-1:0]   ID_EX_rs,
  output logic [REG_W-1:0]   ID_EX_rt,
  output logic [REG_W-1:0]   ID_EX_writeReg,
  output logic               ID_EX_regWrite,
  output logic               ID_EX_memRead,
  output logic               ID_EX_memWrite,
  output logic               ID_EX_memToReg,
  output logic               ID_EX_aluSrc,
  output logic [ALUOP_W-1:0] ID_EX_aluOp,
  output logic [DATA_W-1:0]  ID_EX_rsData,
  output logic [DATA_W-1:0]  ID_EX_rtData,
  output logic [DATA_W-1:0]  ID_EX_imm,
  output logic [DATA_W-1:0]  ID_EX_pc4,
  output logic               stall
`ifdef STALL_COUNT_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_cycles
`endif
);

  ctrl_t             ctrl_q;
  ctrl_t             id_ctrl;
  logic [REG_W-1:0]  rs_q;
  logic [REG_W-1:0]  rt_q;
  logic [REG_W-1:0]  wr_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] pc4_q;
  logic              hz;

  load_use_detect #(
    .REG_W (REG_W)
  ) u_load_use_detect (
    .ex_mem_read (ctrl_q.memRead),
    .ex_rt       (rt_q),
    .id_rs       (IF_ID_rs),
    .id_rt       (IF_ID_rt),
    .hz          (hz)
  );

  // Bundle the decoded ID control into the shared control type.
  always_comb begin
    id_ctrl          = CTRL_BUBBLE;
    id_ctrl.regWrite = id_regWrite;
    id_ctrl.memRead  = id_memRead;
    id_ctrl.memWrite = id_memWrite;
    id_ctrl.memToReg = id_memToReg;
    id_ctrl.aluSrc   = id_aluSrc;
    id_ctrl.aluOp    = id_aluOp;
  end

  // A flush already squashes the dependent instruction, and a freeze holds
  // everything anyway, so neither needs the upstream stages to stall.
  always_comb begin
    stall = hz && !flush && !ext_hold;
  end

  // ID/EX register: freeze, bubble on flush or hazard, otherwise capture ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= CTRL_BUBBLE;
      rs_q      <= '0;
      rt_q      <= '0;
      wr_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      pc4_q     <= '0;
    end else if (ext_hold) begin
      ctrl_q    <= ctrl_q;
      rs_q      <= rs_q;
      rt_q      <= rt_q;
      wr_q      <= wr_q;
      rs_data_q <= rs_data_q;
      rt_data_q <= rt_data_q;
      imm_q     <= imm_q;
      pc4_q     <= pc4_q;
    end else if (flush || hz) begin
      ctrl_q    <= CTRL_BUBBLE;
      rs_q      <= '0;
      rt_q      <= '0;
      wr_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      pc4_q     <= '0;
    end else begin
      ctrl_q    <= id_ctrl;
      rs_q      <= IF_ID_rs;
      rt_q      <= IF_ID_rt;
      wr_q      <= id_regDst ? IF_ID_rd : IF_ID_rt;
      rs_data_q <= id_rsData;
      rt_data_q <= id_rtData;
      imm_q     <= id_imm;
      pc4_q     <= id_pc4;
    end
  end

  // Drive the registered fields onto the named outputs.
  always_comb begin
    ID_EX_rs       = rs_q;
    ID_EX_rt       = rt_q;
    ID_EX_writeReg = wr_q;
    ID_EX_regWrite = ctrl_q.regWrite;
    ID_EX_memRead  = ctrl_q.memRead;
    ID_EX_memWrite = ctrl_q.memWrite;
    ID_EX_memToReg = ctrl_q.memToReg;
    ID_EX_aluSrc   = ctrl_q.aluSrc;
    ID_EX_aluOp    = ctrl_q.aluOp;
    ID_EX_rsData   = rs_data_q;
    ID_EX_rtData   = rt_data_q;
    ID_EX_imm      = imm_q;
    ID_EX_pc4      = pc4_q;
  end

`ifdef STALL_COUNT_EN
  // Event counters; a flush during a freeze is not counted because the
  // flush source holds it until the freeze ends and it is counted then.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (stall) stall_cycles <= stall_cycles + 32'd1;
      if (flush && !ext_hold) flush_cycles <= flush_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: table of ID instructions with hand-derived stall
// expectations, a scoreboard queue of expected ID/EX contents, and a couple
// of hand-written reset/freeze sequences.
module tb_id_ex_stage;

  localparam int LD = 0;
  localparam int BB = 1;
  localparam int KP = 2;

  logic        clk;
  logic        rst;
  logic        ext_hold;
  logic        flush;
  logic [4:0]  IF_ID_rs, IF_ID_rt, IF_ID_rd;
  logic        id_regWrite, id_memRead, id_memWrite, id_memToReg, id_aluSrc, id_regDst;
  logic [3:0]  id_aluOp;
  logic [31:0] id_rsData, id_rtData, id_imm, id_pc4;
  logic [4:0]  ID_EX_rs, ID_EX_rt, ID_EX_writeReg;
  logic        ID_EX_regWrite, ID_EX_memRead, ID_EX_memWrite, ID_EX_memToReg, ID_EX_aluSrc;
  logic [3:0]  ID_EX_aluOp;
  logic [31:0] ID_EX_rsData, ID_EX_rtData, ID_EX_imm, ID_EX_pc4;
  logic        stall;
`ifdef STALL_COUNT_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  id_ex_stage dut (
    .clk            (clk),
    .rst            (rst),
    .ext_hold       (ext_hold),
    .flush          (flush),
    .IF_ID_rs       (IF_ID_rs),
    .IF_ID_rt       (IF_ID_rt),
    .IF_ID_rd       (IF_ID_rd),
    .id_regWrite    (id_regWrite),
    .id_memRead     (id_memRead),
    .id_memWrite    (id_memWrite),
    .id_memToReg    (id_memToReg),
    .id_aluSrc      (id_aluSrc),
    .id_regDst      (id_regDst),
    .id_aluOp       (id_aluOp),
    .id_rsData      (id_rsData),
    .id_rtData      (id_rtData),
    .id_imm         (id_imm),
    .id_pc4         (id_pc4),
    .ID_EX_rs       (ID_EX_rs),
    .ID_EX_rt       (ID_EX_rt),
    .ID_EX_writeReg (ID_EX_writeReg),
    .ID_EX_regWrite (ID_EX_regWrite),
    .ID_EX_memRead  (ID_EX_memRead),
    .ID_EX_memWrite (ID_EX_memWrite),
    .ID_EX_memToReg (ID_EX_memToReg),
    .ID_EX_aluSrc   (ID_EX_aluSrc),
    .ID_EX_aluOp    (ID_EX_aluOp),
    .ID_EX_rsData   (ID_EX_rsData),
    .ID_EX_rtData   (ID_EX_rtData),
    .ID_EX_imm      (ID_EX_imm),
    .ID_EX_pc4      (ID_EX_pc4),
    .stall          (stall)
`ifdef STALL_COUNT_EN
    ,
    .stall_cycles   (stall_cycles),
    .flush_cycles   (flush_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        fl;
    logic        ho;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        rdst;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        asrc;
    logic [3:0]  aop;
    logic [31:0] data;
    logic        es;
    logic [1:0]  act;
  } vec_t;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        asrc;
    logic [3:0]  aop;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic [31:0] pc4;
  } exp_t;

  localparam int NV = 21;
  vec_t vecs [NV];
  exp_t sb_q [$];
  int   checks;
  int   errors;

  function automatic vec_t mk(input logic fl, input logic ho, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd, input logic rdst,
                              input logic rw, input logic mr, input logic mw, input logic m2r,
                              input logic asrc, input logic [3:0] aop, input logic [31:0] data,
                              input logic es, input int act);
    vec_t v;
    v.fl = fl; v.ho = ho; v.rs = rs; v.rt = rt; v.rd = rd; v.rdst = rdst;
    v.rw = rw; v.mr = mr; v.mw = mw; v.m2r = m2r; v.asrc = asrc; v.aop = aop;
    v.data = data; v.es = es; v.act = act[1:0];
    return v;
  endfunction

  function automatic exp_t expect_of(input vec_t v, input exp_t prev);
    exp_t e;
    e = '0;
    if (v.act == KP[1:0]) begin
      e = prev;
    end else if (v.act == LD[1:0]) begin
      e.rs = v.rs; e.rt = v.rt;
      e.wr = v.rdst ? v.rd : v.rt;
      e.rw = v.rw; e.mr = v.mr; e.mw = v.mw; e.m2r = v.m2r; e.asrc = v.asrc; e.aop = v.aop;
      e.rsd = v.data; e.rtd = v.data + 32'd1; e.imm = v.data + 32'd2; e.pc4 = v.data + 32'd3;
    end
    return e;
  endfunction

  function automatic exp_t snap();
    exp_t a;
    a.rs = ID_EX_rs; a.rt = ID_EX_rt; a.wr = ID_EX_writeReg;
    a.rw = ID_EX_regWrite; a.mr = ID_EX_memRead; a.mw = ID_EX_memWrite;
    a.m2r = ID_EX_memToReg; a.asrc = ID_EX_aluSrc; a.aop = ID_EX_aluOp;
    a.rsd = ID_EX_rsData; a.rtd = ID_EX_rtData; a.imm = ID_EX_imm; a.pc4 = ID_EX_pc4;
    return a;
  endfunction

  task automatic drive(input vec_t v);
    flush = v.fl; ext_hold = v.ho;
    IF_ID_rs = v.rs; IF_ID_rt = v.rt; IF_ID_rd = v.rd; id_regDst = v.rdst;
    id_regWrite = v.rw; id_memRead = v.mr; id_memWrite = v.mw;
    id_memToReg = v.m2r; id_aluSrc = v.asrc; id_aluOp = v.aop;
    id_rsData = v.data; id_rtData = v.data + 32'd1;
    id_imm = v.data + 32'd2; id_pc4 = v.data + 32'd3;
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input exp_t exp);
    exp_t act;
    act = snap();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

`ifdef STALL_COUNT_EN
  task automatic chk_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
`endif

  initial begin
    exp_t prev;
    exp_t e;
    vec_t idle;
    checks = 0;
    errors = 0;

    //                fl ho rs rt rd dst rw mr mw m2r as aop data  stall act
    vecs[0]  = mk(0, 0, 1, 2, 3, 1, 1, 0, 0, 0, 0, 2, 100,  0, LD); // add r3,r1,r2
    vecs[1]  = mk(0, 0, 1, 2, 0, 0, 1, 1, 0, 1, 1, 0, 200,  0, LD); // lw r2
    vecs[2]  = mk(0, 0, 2, 5, 4, 1, 1, 0, 0, 0, 0, 2, 300,  1, BB); // add r4,r2,r5 stalls
    vecs[3]  = mk(0, 0, 2, 5, 4, 1, 1, 0, 0, 0, 0, 2, 300,  0, LD); // add enters EX
    vecs[4]  = mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 1, 1, 0, 400,  0, LD); // lw r0
    vecs[5]  = mk(0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 2, 500,  0, LD); // uses r0: no stall
    vecs[6]  = mk(0, 0, 1, 6, 0, 0, 1, 1, 0, 1, 1, 0, 600,  0, LD); // lw r6
    vecs[7]  = mk(0, 0, 7, 8, 0, 0, 0, 0, 1, 0, 1, 0, 700,  0, LD); // sw r8,(r7): no stall
    vecs[8]  = mk(0, 0, 1, 9, 0, 0, 1, 1, 0, 1, 1, 0, 800,  0, LD); // lw r9
    vecs[9]  = mk(1, 0, 3, 9, 10, 1, 1, 0, 0, 0, 0, 2, 900, 0, BB); // hazard + flush
    vecs[10] = mk(0, 0, 3, 9, 10, 1, 1, 0, 0, 0, 0, 2, 1000, 0, LD);
    vecs[11] = mk(0, 0, 1, 2, 0, 0, 1, 1, 0, 1, 1, 0, 1100, 0, LD); // lw r2
    vecs[12] = mk(0, 0, 2, 3, 0, 0, 1, 1, 0, 1, 1, 0, 1200, 1, BB); // lw r3,0(r2)
    vecs[13] = mk(0, 0, 2, 3, 0, 0, 1, 1, 0, 1, 1, 0, 1200, 0, LD);
    vecs[14] = mk(0, 0, 3, 0, 4, 1, 1, 0, 0, 0, 0, 2, 1400, 1, BB); // add r4,r3,r0
    vecs[15] = mk(0, 0, 3, 0, 4, 1, 1, 0, 0, 0, 0, 2, 1400, 0, LD);
    vecs[16] = mk(0, 0, 1, 5, 0, 0, 1, 1, 0, 1, 1, 0, 1600, 0, LD); // lw r5
    vecs[17] = mk(1, 1, 5, 5, 6, 1, 1, 0, 0, 0, 0, 2, 1700, 0, KP); // freeze, hazard, flush
    vecs[18] = mk(0, 1, 2, 3, 4, 1, 1, 0, 1, 0, 0, 7, 1800, 0, KP);
    vecs[19] = mk(1, 1, 5, 1, 1, 1, 0, 0, 0, 0, 0, 3, 1900, 0, KP);
    vecs[20] = mk(0, 0, 1, 2, 3, 1, 1, 0, 0, 0, 0, 5, 2000, 0, LD); // release: loads

    idle = '0;
    drive(idle);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset_state", '0);
    chk_bit("reset_stall", stall, 1'b0);
`ifdef STALL_COUNT_EN
    chk_word("reset_stall_cycles", stall_cycles, 32'd0);
    chk_word("reset_flush_cycles", flush_cycles, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    prev = '0;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk_bit($sformatf("stall[%0d]", i), stall, vecs[i].es);
      e = expect_of(vecs[i], prev);
      sb_q.push_back(e);
      prev = e;
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard[%0d]: got empty queue expected entry", i);
      end else begin
        chk_state($sformatf("id_ex[%0d]", i), sb_q.pop_front());
      end
    end

`ifdef STALL_COUNT_EN
    chk_word("stall_cycles", stall_cycles, 32'd3);
    chk_word("flush_cycles", flush_cycles, 32'd1);
`endif

    // Reset must win over a freeze while a load-use hazard is pending.
    @(negedge clk);
    drive(mk(0, 0, 1, 2, 0, 0, 1, 1, 0, 1, 1, 0, 3000, 0, LD));
    @(posedge clk);
    #1;
    chk_bit("lw_loaded_memRead", ID_EX_memRead, 1'b1);
    @(negedge clk);
    drive(mk(0, 1, 2, 2, 3, 1, 1, 0, 0, 0, 0, 2, 3100, 0, KP));
    rst = 1'b1;
    #1;
    chk_bit("hold_hazard_stall", stall, 1'b0);
    @(posedge clk);
    #1;
    chk_state("rst_over_hold", '0);
    chk_bit("rst_over_hold_stall", stall, 1'b0);
`ifdef STALL_COUNT_EN
    chk_word("rst_stall_cycles", stall_cycles, 32'd0);
    chk_word("rst_flush_cycles", flush_cycles, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    drive(idle);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
